// File: rtl/delay_line_pkg.sv
// -----------------------------------------------------------------------------
// delay_line_pkg
// Shared constants and helpers for the delay_line block.
//   len_width(max_len) : width needed to hold a delay length 0..max_len
//   DEF_*              : default parameter values used by delay_line
// -----------------------------------------------------------------------------
package delay_line_pkg;

    localparam int DEF_DATA_WIDTH = 25;
    localparam int DEF_CHANNELS   = 1;
    localparam int DEF_MAX_LEN    = 512;
    localparam int DEF_LEN_INIT   = 512;

    // A length register must reach MAX_LEN itself, hence the +1.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/delay_line_sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
// Inferred simple-dual-port RAM: one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the old word
// (read-first).
// Ports:
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata updates only when high
//   raddr : read address
//   rdata : registered read data
// -----------------------------------------------------------------------------
module sdp_ram #(
    parameter int DW    = 25,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/delay_line.sv
// -----------------------------------------------------------------------------
// delay_line
// Programmable delay of a multi-channel sample stream, counted in beats
// (cycles with ce_i high). Samples live in an inferred RAM; the output is
// masked to zero until enough beats have been seen since reset or the last
// length load.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   ce_i      : beat strobe
//   di        : input samples, channel 0 in LSBs
//   len_i     : requested delay in beats
//   len_ld_i  : load strobe for len_i (flushes the line)
//   data_o    : delayed samples, zero while valid_o is low
//   valid_o   : data_o holds a real delayed sample
//   len_err_o : sticky, an out-of-range len_i was loaded
// Build option:
//   DELAY_LINE_OUT_REG_EN : adds one output register stage (one more clk of
//                           latency on data_o/valid_o)
// -----------------------------------------------------------------------------
module delay_line
    import delay_line_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int LEN_INIT   = DEF_LEN_INIT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce_i,
    input  logic [DATA_WIDTH*CHANNELS-1:0] di,
    input  logic [len_width(MAX_LEN)-1:0]  len_i,
    input  logic                           len_ld_i,
    output logic [DATA_WIDTH*CHANNELS-1:0] data_o,
    output logic                           valid_o,
    output logic                           len_err_o
);

    localparam int              LW        = len_width(MAX_LEN);
    localparam int              AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int              WW        = DATA_WIDTH * CHANNELS;
    localparam logic [LW:0]     MAX_LEN_X = (LW + 1)'(MAX_LEN);
    localparam logic [LW-1:0]   LEN_MAX   = LW'(MAX_LEN);
    localparam logic [LW-1:0]   LEN_RST   = LW'(LEN_INIT);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(MAX_LEN - 1);

    logic [AW-1:0] wp;
    logic [LW-1:0] len_r;
    logic [LW-1:0] fill_r;
    logic          valid_r;
    logic          byp_sel_r;
    logic [WW-1:0] byp_r;
    logic          err_r;

    logic [LW-1:0] len_clamped;
    logic          len_bad;
    logic [LW-1:0] len_eff;
    logic [LW-1:0] fill_base;
    logic [LW-1:0] fill_nxt;
    logic [LW:0]   wp_x;
    logic [LW:0]   back;
    logic [LW:0]   rd_sum;
    logic [AW-1:0] rd_addr;
    logic [WW-1:0] ram_q;
    logic [WW-1:0] data_mux;

    // A load takes effect on the same cycle, so a concurrent beat already
    // uses the new length and counts as the first beat of the fresh fill.
    always_comb begin
        len_clamped = len_i;
        len_bad     = 1'b0;
        if (len_i == '0) begin
            len_clamped = LW'(1);
            len_bad     = 1'b1;
        end else if ({1'b0, len_i} > MAX_LEN_X) begin
            len_clamped = LEN_MAX;
            len_bad     = 1'b1;
        end
        len_eff   = len_ld_i ? len_clamped : len_r;
        fill_base = len_ld_i ? '0 : fill_r;
        fill_nxt  = (fill_base == LEN_MAX) ? fill_base : fill_base + LW'(1);
    end

    // The sample for delay L was written L-1 beats ago: read address is
    // wp-(L-1) modulo MAX_LEN. For L>=2 this never collides with wp; L=1 is
    // served from the bypass register instead.
    always_comb begin
        wp_x   = (LW + 1)'(wp);
        back   = {1'b0, len_eff} - (LW + 1)'(1);
        rd_sum = '0;
        if (wp_x >= back) begin
            rd_sum = wp_x - back;
        end else begin
            rd_sum = wp_x + MAX_LEN_X - back;
        end
        rd_addr = rd_sum[AW-1:0];
    end

    sdp_ram #(
        .DW    (WW),
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ce_i),
        .waddr (wp),
        .wdata (di),
        .re    (ce_i),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            len_r     <= LEN_RST;
            fill_r    <= '0;
            valid_r   <= 1'b0;
            byp_sel_r <= 1'b0;
            byp_r     <= '0;
            err_r     <= 1'b0;
        end else begin
            if (len_ld_i) begin
                len_r <= len_clamped;
                if (len_bad) begin
                    err_r <= 1'b1;
                end
            end
            if (ce_i) begin
                wp        <= (wp == LAST_ADDR) ? '0 : wp + AW'(1);
                fill_r    <= fill_nxt;
                valid_r   <= (fill_nxt >= len_eff);
                byp_sel_r <= (len_eff == LW'(1));
                byp_r     <= di;
            end else if (len_ld_i) begin
                fill_r  <= '0;
                valid_r <= 1'b0;
            end
        end
    end

    // RAM contents are never cleared, so stale words must be hidden here.
    always_comb begin
        data_mux = '0;
        if (valid_r) begin
            data_mux = byp_sel_r ? byp_r : ram_q;
        end
    end

    assign len_err_o = err_r;

`ifdef DELAY_LINE_OUT_REG_EN
    logic [WW-1:0] data_q;
    logic          valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_mux;
            valid_q <= valid_r;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
`else
    assign data_o  = data_mux;
    assign valid_o = valid_r;
`endif

endmodule

// File: tb/tb_delay_line.sv
// -----------------------------------------------------------------------------
// tb_delay_line
// Bench for delay_line with CHANNELS=2, MAX_LEN=16, LEN_INIT=10. A queue of
// samples accepted since the last flush gives the expected output for any
// delay L; with DELAY_LINE_OUT_REG_EN the expectation is pushed back one clk.
// -----------------------------------------------------------------------------
module tb_delay_line;

    localparam int DW = 12;
    localparam int CH = 2;
    localparam int ML = 16;
    localparam int LI = 10;
    localparam int WW = DW * CH;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce_i = 1'b0;
    logic [WW-1:0] di = '0;
    logic [LW-1:0] len_i = '0;
    logic          len_ld_i = 1'b0;
    logic [WW-1:0] data_o;
    logic          valid_o;
    logic          len_err_o;

    delay_line #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .MAX_LEN    (ML),
        .LEN_INIT   (LI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce_i      (ce_i),
        .di        (di),
        .len_i     (len_i),
        .len_ld_i  (len_ld_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .len_err_o (len_err_o)
    );

    always #5 clk = ~clk;

    logic [WW-1:0] hist [$];
    int            m_len;
    bit            m_err;
    bit            cur_valid, prev_valid, exp_valid;
    logic [WW-1:0] cur_data, prev_data, exp_data;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    function automatic logic [WW-1:0] ramp(input int r);
        return {DW'(r), DW'(r)};
    endfunction

    task automatic modelReset();
        hist.delete();
        m_len      = LI;
        m_err      = 1'b0;
        cur_valid  = 1'b0;
        prev_valid = 1'b0;
        exp_valid  = 1'b0;
        cur_data   = '0;
        prev_data  = '0;
        exp_data   = '0;
    endtask

    task automatic checkOutput(input string tag);
        check_count++;
        assert (valid_o === exp_valid) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s valid_o: got %0b expected %0b", tag, valid_o, exp_valid);
        end
        check_count++;
        assert (data_o === exp_data) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s data_o: got %h expected %h", tag, data_o, exp_data);
        end
        check_count++;
        assert (len_err_o === m_err) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s len_err_o: got %0b expected %0b", tag, len_err_o, m_err);
        end
    endtask

    // One clk cycle: drive on the falling edge, update the model at the
    // rising edge, compare shortly after it.
    task automatic applyStimulus(input bit ce, input logic [WW-1:0] d,
                                 input bit ld, input int len, input string tag);
        @(negedge clk);
        ce_i     = ce;
        di       = d;
        len_ld_i = ld;
        len_i    = LW'(len);
        @(posedge clk);
        if (ld) begin
            if (len == 0) begin
                m_len = 1;
                m_err = 1'b1;
            end else if (len > ML) begin
                m_len = ML;
                m_err = 1'b1;
            end else begin
                m_len = len;
            end
            hist.delete();
            cur_valid = 1'b0;
            cur_data  = '0;
        end
        if (ce) begin
            hist.push_back(d);
            if (hist.size() > ML) begin
                void'(hist.pop_front());
            end
            cur_valid = (hist.size() >= m_len);
            cur_data  = cur_valid ? hist[hist.size() - m_len] : '0;
        end
`ifdef DELAY_LINE_OUT_REG_EN
        exp_valid  = prev_valid;
        exp_data   = prev_data;
        prev_valid = cur_valid;
        prev_data  = cur_data;
`else
        exp_valid = cur_valid;
        exp_data  = cur_data;
`endif
        #1;
        checkOutput(tag);
    endtask

    // Asserted between edges: outputs must clear without waiting for a clock.
    task automatic pulseReset();
        #2;
        rst      = 1'b1;
        ce_i     = 1'b0;
        len_ld_i = 1'b0;
        #1;
        modelReset();
        checkOutput("reset_async");
        #8;
        rst = 1'b0;
    endtask

    initial begin
        modelReset();
        #3;
        checkOutput("reset_init");
        #9;
        rst = 1'b0;

        for (int r = 0; r < 14; r++) applyStimulus(1'b1, ramp(r), 1'b0, 0, "ramp_l10");

        applyStimulus(1'b1, ramp(14), 1'b1, 5, "load5_concurrent");
        for (int r = 15; r < 23; r++) applyStimulus(1'b1, ramp(r), 1'b0, 0, "after_load5");

        applyStimulus(1'b0, '0, 1'b1, 4, "load4");
        for (int i = 0; i < 18; i++)
            applyStimulus((i % 3) == 0, WW'($urandom), 1'b0, 0, "ce_third_l4");

        applyStimulus(1'b0, '0, 1'b1, 1, "load1");
        for (int i = 0; i < 8; i++)
            applyStimulus(i != 3, WW'($urandom), 1'b0, 0, "l1_bypass");

        applyStimulus(1'b1, WW'($urandom), 1'b1, 0, "load0_err");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, WW'($urandom), 1'b0, 0, "l1_after_err");

        applyStimulus(1'b0, '0, 1'b1, 20, "load20_err");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, WW'($urandom), 1'b0, 0, "l16_max");

        applyStimulus(1'b1, WW'($urandom), 1'b1, 7, "load7");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, WW'($urandom), 1'b0, 0, "l7");
        applyStimulus(1'b0, '0, 1'b1, 7, "reload_same_len");
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, WW'($urandom), 1'b0, 0, "l7_refill");

        pulseReset();
        for (int r = 0; r < 12; r++) applyStimulus(1'b1, ramp(100 + r), 1'b0, 0, "after_reset");

        for (int i = 0; i < 300; i++) begin
            if (i == 150) pulseReset();
            applyStimulus($urandom_range(0, 3) != 0, WW'($urandom),
                          $urandom_range(0, 29) == 0, int'($urandom_range(0, 20)), "random");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 25, bits per channel sample.
REQ-002 SHALL have parameter CHANNELS, default 1, number of parallel channels sharing one delay.
REQ-003 SHALL have parameter MAX_LEN, default 512, maximum delay in beats (any integer >= 2).
REQ-004 SHALL have parameter LEN_INIT, default 512, delay applied out of reset (1..MAX_LEN).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port ce_i  input  1  beat strobe; one sample accepted per cycle when high.
REQ-008 SHALL have port di  input  DATA_WIDTH*CHANNELS  input samples, channel 0 in LSBs.
REQ-009 SHALL have port len_i  input  LW=$clog2(MAX_LEN+1)  requested delay in beats.
REQ-010 SHALL have port len_ld_i  input  1  load strobe for len_i.
REQ-011 SHALL have port data_o  output  DATA_WIDTH*CHANNELS  delayed samples.
REQ-012 SHALL have port valid_o  output  1  data_o holds a real delayed sample.
REQ-013 SHALL have port len_err_o  output  1  sticky flag: out-of-range len_i was loaded.

Function
REQ-014 Storage SHALL be an inferred simple-dual-port RAM, MAX_LEN words of DATA_WIDTH*CHANNELS bits; no vendor macros.
REQ-015 Write pointer SHALL advance by 1 per ce_i beat, wrapping MAX_LEN-1 -> 0; cycles with ce_i low SHALL change no state except len load.
REQ-016 With active delay L, after beat n data_o SHALL equal di of beat n-L+1 (L=1: data_o equals di of the same beat, via bypass).
REQ-017 data_o/valid_o SHALL update one clk after the accepting beat and hold between beats.
REQ-018 A fill counter SHALL count beats since reset/load, saturating at MAX_LEN; valid_o SHALL be high after a beat iff fill count >= L.
REQ-019 data_o SHALL be all-zero whenever valid_o is low.
REQ-020 On len_ld_i, L SHALL take len_i; len_i=0 SHALL load 1, len_i>MAX_LEN SHALL load MAX_LEN, and either case SHALL set len_err_o.
REQ-021 A load SHALL flush: fill counter cleared, valid_o low next cycle; write pointer and RAM contents unchanged.
REQ-022 Simultaneous len_ld_i and ce_i: the new L applies, that beat's sample is written and counts as fill beat 1.
REQ-023 len_ld_i with len_i equal to current L SHALL still flush.

Reset
REQ-024 rst SHALL asynchronously clear write pointer, fill counter, data_o (0), valid_o (0), len_err_o (0) and set L=LEN_INIT.
REQ-025 RAM contents SHALL not be cleared; stale words are masked by REQ-018/REQ-019.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight samples; first valid_o after release follows L fresh beats.

Configuration
REQ-027 Macro DELAY_LINE_OUT_REG_EN SHALL, when defined, add one output register stage: data_o and valid_o delayed one further clk cycle (not beat), reset to 0.
REQ-028 Without DELAY_LINE_OUT_REG_EN, latency SHALL be exactly as REQ-017.

Structure
REQ-029 Shared package delay_line_pkg SHALL hold LW width function and default parameter constants.
REQ-030 Sub-module sdp_ram (one write port, one synchronous read port, read-first) SHALL implement storage.

Verification
REQ-031 CHANNELS=2, MAX_LEN=16, L=10, ce_i constant high, di ramp 0,1,2..: valid_o rises after beat 9; data_o = ramp-9 on both channels.
REQ-032 L=4, ce_i high every third cycle: data_o changes only after beats, equals sample of beat n-3.
REQ-033 L=1: data_o equals di one cycle later, valid_o high after first beat.
REQ-034 Mid-stream len_ld_i with len_i=5 (from 10), concurrent ce_i: valid_o low next cycle, high again after 5th beat, data_o = beat n-4.
REQ-035 len_i=0 then len_i=20 with MAX_LEN=16: L becomes 1 then 16, len_err_o high and stays until rst.
REQ-036 rst pulsed mid-stream (async, off clock edge): outputs 0 immediately; after release, valid_o after LEN_INIT beats; repeat with DELAY_LINE_OUT_REG_EN for +1 cycle.
